// File: rtl/gate_chain_pkg.sv
// Shared types and helpers for the gate-chain arbiter slice.
// Gate op encodings, operand field offsets and the gate function.
package gate_chain_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_NAND = 2'd3
  } gate_op_e;

  localparam int OPND_W  = 3;
  localparam int A_BIT   = 0;
  localparam int SEL_BIT = 1;
  localparam int C_BIT   = 2;

  function automatic logic gate_op(
    input gate_op_e op,
    input logic     x,
    input logic     y
  );
    logic r;
    r = x & y;
    case (op)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_NAND: r = ~(x & y);
      default: r = x & y;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_chain_arbiter_if.sv
// Requester/consumer bundle of the gate-chain arbiter.
// The slave side is the arbiter; the master side drives requests.
interface gate_chain_arbiter_if
  import gate_chain_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]        req;
  logic [OPND_W*N_REQ-1:0] opnd;
  logic [N_REQ-1:0]        gnt;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic                    rsp_y;
  logic [ID_W-1:0]         rsp_id;
  logic                    busy;

  modport master (
    output req, opnd, rsp_ready,
    input  gnt, rsp_valid, rsp_y, rsp_id, busy
  );

  modport slave (
    input  req, opnd, rsp_ready,
    output gnt, rsp_valid, rsp_y, rsp_id, busy
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req at or after ptr.
// Produces a one-hot grant, its encoded index and an any-grant flag.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_idx,
  output logic             any_gnt
);

  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    for (int o = 0; o < N_REQ; o++) begin
      idx = (int'(ptr) + o) % N_REQ;
      if (en && !any_gnt && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = ID_W'(idx);
        any_gnt  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gate_chain_arbiter.sv
// Round-robin sequencer feeding a shared two-stage gate chain.
// y = OP(OP(a, sel), c), tagged with the requester id.
module gate_chain_arbiter
  import gate_chain_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int GATE_OP = 0
) (
  input logic                clk,
  input logic                rst_n,
  gate_chain_arbiter_if.slave bus
);

  if (GATE_OP < 0 || GATE_OP > 3) begin : g_bad_op
    $error("gate_chain_arbiter: GATE_OP must be 0..3");
  end
  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n
    $error("gate_chain_arbiter: N_REQ must be 2..8");
  end
  if (ID_W != $clog2(N_REQ)) begin : g_bad_w
    $error("gate_chain_arbiter: ID_W must be clog2(N_REQ)");
  end

  localparam logic [31:0] OP_RAW = GATE_OP;
  localparam gate_op_e    OP     = gate_op_e'(OP_RAW[1:0]);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            s1_valid_q, s1_valid_d;
  logic            s1_n1_q, s1_n1_d;
  logic            s1_c_q, s1_c_d;
  logic [ID_W-1:0] s1_id_q, s1_id_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_y_q, rsp_y_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;

  logic              stall;
  logic              en;
  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic              any_gnt;
  logic [OPND_W-1:0] sel_opnd;

  assign stall = rsp_valid_q & ~bus.rsp_ready;
  // Reset also masks grants so nothing is handshaken while held.
  assign en    = rst_n & ~stall;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .req     (bus.req),
    .ptr     (ptr_q),
    .en      (en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  always_comb begin
    sel_opnd = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_opnd = sel_opnd | bus.opnd[OPND_W*i +: OPND_W];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (any_gnt) begin
      if (int'(gnt_idx) == N_REQ - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_idx + 1'b1;
      end
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_n1_d     = s1_n1_q;
    s1_c_d      = s1_c_q;
    s1_id_d     = s1_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_y_d     = rsp_y_q;
    rsp_id_d    = rsp_id_q;
    if (!stall) begin
      s1_valid_d = any_gnt;
      if (any_gnt) begin
        s1_n1_d = gate_op(OP, sel_opnd[A_BIT], sel_opnd[SEL_BIT]);
        s1_c_d  = sel_opnd[C_BIT];
        s1_id_d = gnt_idx;
      end
      rsp_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        rsp_y_d  = gate_op(OP, s1_n1_q, s1_c_q);
        rsp_id_d = s1_id_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_n1_q     <= 1'b0;
      s1_c_q      <= 1'b0;
      s1_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_y_q     <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_n1_q     <= s1_n1_d;
      s1_c_q      <= s1_c_d;
      s1_id_q     <= s1_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_y_q     <= rsp_y_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign bus.gnt       = gnt;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_y     = rsp_y_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.busy      = s1_valid_q | rsp_valid_q;

endmodule

// File: tb/tb_gate_chain_arbiter.sv
// Directed bench for gate_chain_arbiter (GATE_OP = AND).
// Driver queues expected {y,id} on each grant; monitor pops on accept.
module tb_gate_chain_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  gate_chain_arbiter_if #(.N_REQ(4), .ID_W(2)) bus ();

  gate_chain_arbiter #(
    .N_REQ   (4),
    .ID_W    (2),
    .GATE_OP (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [2:0] exp_q[$];

  // {c,sel,a} per requester, r3..r0; AND chain gives y = a&sel&c
  localparam logic [11:0] OPA = {3'b110, 3'b111, 3'b011, 3'b111};
  localparam logic [11:0] OPB = {3'b110, 3'b111, 3'b011, 3'b011};
  localparam logic [11:0] OPC = {3'b110, 3'b111, 3'b111, 3'b111};

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic [3:0] r,
                      input logic [11:0] op, input logic rdy,
                      input logic [3:0] eg, input logic ey);
    logic [1:0] id;
    @(posedge clk);
    #2;
    rst_n         = rst;
    bus.req       = r;
    bus.opnd      = op;
    bus.rsp_ready = rdy;
    if (!rst) exp_q.delete();
    #1;
    chk("gnt", 8'(bus.gnt), 8'(eg));
    if (eg != 4'b0) begin
      id = 2'd0;
      for (int i = 0; i < 4; i++) if (eg[i]) id = 2'(i);
      exp_q.push_back({ey, id});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 4'b0, OPA, 1'b1, 4'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got id %0d y %0b want none at %0t",
                 bus.rsp_id, bus.rsp_y, $time);
      end else begin
        chk("rsp_y", 8'(bus.rsp_y), 8'(exp_q[0][2]));
        chk("rsp_id", 8'(bus.rsp_id), 8'(exp_q[0][1:0]));
        if (bus.rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  int   rr_ids[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
  logic yv[4]     = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    bus.req       = 4'hF;
    bus.opnd      = OPA;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_gnt", 8'(bus.gnt), 8'h0);
    chk("rst_valid", 8'(bus.rsp_valid), 8'h0);
    chk("rst_busy", 8'(bus.busy), 8'h0);
    @(posedge clk);

    // idle after reset
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'b0, OPA, 1'b1, 4'b0, 1'b0);
      chk("idle_valid", 8'(bus.rsp_valid), 8'h0);
      chk("idle_busy", 8'(bus.busy), 8'h0);
    end

    // single request and its two-cycle latency
    step(1'b1, 4'b0001, OPA, 1'b1, 4'b0001, 1'b1);
    step(1'b1, 4'b0000, OPA, 1'b1, 4'b0000, 1'b0);
    chk("lat_t1_valid", 8'(bus.rsp_valid), 8'h0);
    chk("lat_t1_busy", 8'(bus.busy), 8'h1);
    step(1'b1, 4'b0000, OPA, 1'b1, 4'b0000, 1'b0);
    chk("lat_t2_valid", 8'(bus.rsp_valid), 8'h1);
    idle(2);
    step(1'b1, 4'b0001, OPB, 1'b1, 4'b0001, 1'b0);
    idle(3);

    // round robin from ptr=1, no bubbles
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 4'hF, OPA, 1'b1, 4'(1 << rr_ids[i]), yv[rr_ids[i]]);
      if (i >= 2) chk("no_bubble", 8'(bus.rsp_valid), 8'h1);
    end
    idle(3);

    // backpressure: 4 stalled cycles once the first result shows
    step(1'b1, 4'hF, OPA, 1'b1, 4'b0010, 1'b0);
    step(1'b1, 4'hF, OPA, 1'b1, 4'b0100, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'hF, OPA, 1'b0, 4'b0000, 1'b0);
      chk("stall_valid", 8'(bus.rsp_valid), 8'h1);
    end
    step(1'b1, 4'hF, OPA, 1'b1, 4'b1000, 1'b0);
    step(1'b1, 4'hF, OPA, 1'b1, 4'b0001, 1'b1);
    idle(4);

    // wrap and skip: serve 2 -> ptr=3, then 0101 gives 0 then 2
    step(1'b1, 4'b0100, OPA, 1'b1, 4'b0100, 1'b1);
    step(1'b1, 4'b0101, OPA, 1'b1, 4'b0001, 1'b1);
    step(1'b1, 4'b0101, OPA, 1'b1, 4'b0100, 1'b1);
    idle(4);

    // reset one cycle after a grant; in-flight result is dropped
    step(1'b1, 4'b0010, OPC, 1'b1, 4'b0010, 1'b1);
    step(1'b0, 4'b1010, OPC, 1'b1, 4'b0000, 1'b0);
    chk("mid_rst_valid", 8'(bus.rsp_valid), 8'h0);
    chk("mid_rst_busy", 8'(bus.busy), 8'h0);
    chk("mid_rst_y", 8'(bus.rsp_y), 8'h0);
    chk("mid_rst_id", 8'(bus.rsp_id), 8'h0);
    step(1'b0, 4'b1010, OPC, 1'b1, 4'b0000, 1'b0);
    step(1'b1, 4'b1010, OPC, 1'b1, 4'b0010, 1'b1);
    step(1'b1, 4'b0000, OPC, 1'b1, 4'b0000, 1'b0);

    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      idle(1);
    end
    idle(1);
    chk("drain_left", 8'(exp_q.size()), 8'h0);
    chk("end_busy", 8'(bus.busy), 8'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_chain_arbiter.md
Name: gate_chain_arbiter

Overview:
- Round-robin arbiter and pipeline sequencer that shares one two-stage gate chain among N_REQ requesters.
- Chain function: y = OP(OP(a, sel), c).
- Each requester presents a 3-bit operand set (a, sel, c) under a req/gnt handshake.
- The block issues at most one operand set per cycle into a 2-stage registered chain and returns the result tagged with the requester id.
- Sits between the lab's stimulus/requester logic and the shared gate-chain datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester id; must equal clog2(N_REQ).
- GATE_OP, 0, gate function used by both stages: 0=AND, 1=OR, 2=XOR, 3=NAND.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  N_REQ  per-requester request; held high until granted
- opnd  input  3*N_REQ  operands; requester i uses bits [3i+2:3i] = {c, sel, a}
- gnt  output  N_REQ  one-hot grant, combinational; a transfer occurs when req[i] and gnt[i] are both high
- rsp_valid  output  1  result valid
- rsp_ready  input  1  consumer accepts the result
- rsp_y  output  1  chain result
- rsp_id  output  ID_W  requester index of the result
- busy  output  1  any pipeline stage holds valid data

Behaviour:
- Reset (async assert, synchronous-safe deassert):
  - stage valids = 0, rr_ptr = 0
  - rsp_valid = 0, rsp_y = 0, rsp_id = 0, busy = 0
  - gnt = 0 while rst_n is low
- Arbitration:
  - Search req starting at index rr_ptr, wrapping modulo N_REQ.
  - The first set bit gets gnt; at most one gnt bit is high.
  - gnt = 0 when no req is set or stall is high.
- Pointer update: on a transfer to index k, rr_ptr <= (k+1) mod N_REQ. Otherwise rr_ptr holds.
- stall = rsp_valid & ~rsp_ready.
- Stage 1, on a transfer at edge t:
  - s1_valid <= 1
  - s1_n1 <= OP(a, sel)
  - s1_c <= c
  - s1_id <= k
- Stage 2, at edge t+1:
  - rsp_valid <= s1_valid
  - rsp_y <= OP(s1_n1, s1_c)
  - rsp_id <= s1_id
- Latency: a grant in cycle t gives rsp_valid high in cycle t+2. Throughput is 1 result per cycle when no stall.
- Stall: while stall is high:
  - all stage registers hold
  - gnt forced to 0
  - rr_ptr holds
  - no data is dropped or duplicated
- Bubbles:
  - If there is no transfer and no stall, s1_valid <= 0.
  - If rsp_valid & rsp_ready and s1_valid = 0, rsp_valid <= 0 next cycle.
- busy = s1_valid | rsp_valid.
- Simultaneous events:
  - Pipeline advance and a new grant happen in the same cycle when rsp_ready is high.
  - A request deasserted before grant is not an error; it is simply not served.
- Reset mid-operation: in-flight results are discarded with no rsp_valid pulse. After reset, arbitration restarts at index 0.
- OP is selected by GATE_OP at elaboration. Any other GATE_OP value is an elaboration error.

Decomposition:
- Shared package gate_chain_pkg:
  - gate op encodings: OP_AND, OP_OR, OP_XOR, OP_NAND
  - function gate_op(op, x, y)
  - operand field offsets A_BIT=0, SEL_BIT=1, C_BIT=2
- Sub-module rr_arbiter:
  - parameter N_REQ
  - inputs: req, ptr, en
  - outputs: one-hot gnt, encoded gnt_idx, any_gnt
- The top level owns the pointer register, the pipeline and the stall logic.

Test Plan:
- Reset then idle: rst_n low 3 cycles, then high with req = 0 -> gnt = 0, rsp_valid = 0, busy = 0 for 10 cycles.
- Single request, GATE_OP=0:
  - stimulus: req = 0001, opnd[2:0] = {c=1, sel=1, a=1}
  - expected: gnt = 0001 in cycle t; rsp_valid = 1, rsp_y = 1, rsp_id = 0 at t+2; rr_ptr = 1
  - repeat with c = 0 -> rsp_y = 0
- Round-robin fairness:
  - stimulus: req = 1111 held for 8 cycles, rsp_ready = 1
  - expected: grant order 0,1,2,3,0,1,2,3; rsp_id follows the same order 2 cycles later with no bubbles
- Backpressure:
  - stimulus: req = 1111, rsp_ready = 0 for 4 cycles after the first rsp_valid
  - expected: gnt = 0 during the stall; rsp_y and rsp_id hold; after release, ids continue with no loss or duplicate
- Wrap and skip:
  - stimulus: rr_ptr = 3 (after serving 2), req = 0101
  - expected: grant goes to index 0 next, then 2
- Reset mid-flight:
  - stimulus: assert rst_n low one cycle after a grant
  - expected: rsp_valid never pulses for that request; outputs zero immediately; next grant after release goes to the lowest requesting index from 0
